// File: rtl/math_adder_rr_scheduler_016.sv
// ============================================================================
// Module   : math_adder_rr_scheduler_016
// Brief    : Round-robin scheduler sharing one Brent-Kung adder among requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module math_adder_brent_kung_016 #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_c,
    output logic [N-1:0] o_sum,
    output logic         o_carry
);
    localparam int L = (N > 1) ? $clog2(N) : 1;
    localparam int P = 1 << L;
    localparam int S = 2 * L - 1;

    logic [P-1:0] a_pad;
    logic [P-1:0] b_pad;
    logic [P-1:0] p0;
    logic [P-1:0] g [0:S];
    logic [P-1:0] p [0:S-1];

    always_comb begin
        a_pad        = '0;
        b_pad        = '0;
        a_pad[N-1:0] = i_a;
        b_pad[N-1:0] = i_b;
    end

    // Carry-in is folded into bit 0's generate so the prefix tree yields carries directly.
    assign p0   = a_pad ^ b_pad;
    assign p[0] = p0;
    assign g[0] = (a_pad & b_pad) | {{(P-1){1'b0}}, p0[0] & i_c};

    genvar s, i;
    generate
        for (s = 1; s <= S; s++) begin : g_stage
            for (i = 0; i < P; i++) begin : g_bit
                localparam bit UP   = (s <= L);
                localparam int DIST = UP ? (1 << (s - 1)) : (1 << (2 * L - 1 - s));
                localparam bit ACT  = UP ? (((i + 1) % (2 * DIST)) == 0)
                                         : ((((i + 1) % (2 * DIST)) == DIST) && (i >= 3 * DIST - 1));
                if (ACT) begin : g_op
                    assign g[s][i] = g[s-1][i] | (p[s-1][i] & g[s-1][i-DIST]);
                    if (s < S) begin : g_prop
                        assign p[s][i] = p[s-1][i] & p[s-1][i-DIST];
                    end
                end else begin : g_pass
                    assign g[s][i] = g[s-1][i];
                    if (s < S) begin : g_prop
                        assign p[s][i] = p[s-1][i];
                    end
                end
            end
        end
    endgenerate

    assign o_sum   = p0[N-1:0] ^ {g[S][N-2:0], i_c};
    assign o_carry = g[S][N-1];
endmodule

module math_adder_rr_scheduler_016 #(
    parameter int N       = 16,
    parameter int NUM_REQ = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*N-1:0]       i_req_a,
    input  logic [NUM_REQ*N-1:0]       i_req_b,
    input  logic [NUM_REQ-1:0]         i_req_c,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [N-1:0]               o_rsp_sum,
    output logic                       o_rsp_carry,
    output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
    output logic                       o_busy
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    logic           op_c_q, op_c_d;
    logic [IDW-1:0] op_id_q, op_id_d;
    logic [N-1:0]   rsp_sum_q, rsp_sum_d;
    logic           rsp_carry_q, rsp_carry_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           busy_q, busy_d;

    logic           grant_found;
    logic [IDW-1:0] grant_id;
    int             idx;
    logic [N-1:0]   add_sum;
    logic           add_carry;

    // First valid requester at or above the pointer, wrapping at NUM_REQ-1.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && i_req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign o_req_ready = (state_q == ST_IDLE && grant_found)
                       ? (NUM_REQ'(1) << grant_id) : '0;

    math_adder_brent_kung_016 #(
        .N (N)
    ) u_adder (
        .i_a     (op_a_q),
        .i_b     (op_b_q),
        .i_c     (op_c_q),
        .o_sum   (add_sum),
        .o_carry (add_carry)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_c_d      = op_c_q;
        op_id_d     = op_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    op_a_d  = i_req_a[grant_id*N +: N];
                    op_b_d  = i_req_b[grant_id*N +: N];
                    op_c_d  = i_req_c[grant_id];
                    op_id_d = grant_id;
                    ptr_d   = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + IDW'(1);
                    state_d = ST_CALC;
                    busy_d  = 1'b1;
                end
            end
            ST_CALC: begin
                rsp_sum_d   = add_sum;
                rsp_carry_d = add_carry;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c_q      <= 1'b0;
            op_id_q     <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_c_q      <= op_c_d;
            op_id_q     <= op_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_sum   = rsp_sum_q;
    assign o_rsp_carry = rsp_carry_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_busy      = busy_q;
endmodule

`default_nettype wire

// File: tb/tb_math_adder_rr_scheduler_016.sv
// ============================================================================
// Module   : tb_math_adder_rr_scheduler_016
// Brief    : Directed-vector bench for the round-robin adder scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_math_adder_rr_scheduler_016;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [3:0]  i_req_valid;
    logic [3:0]  o_req_ready;
    logic [63:0] i_req_a;
    logic [63:0] i_req_b;
    logic [3:0]  i_req_c;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [15:0] o_rsp_sum;
    logic        o_rsp_carry;
    logic [1:0]  o_rsp_id;
    logic        o_busy;

    int vectors    = 0;
    int miscompares = 0;

    math_adder_rr_scheduler_016 #(.N(16), .NUM_REQ(4)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .i_req_c     (i_req_c),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_sum   (o_rsp_sum),
        .o_rsp_carry (o_rsp_carry),
        .o_rsp_id    (o_rsp_id),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b, input logic c);
        i_req_a[k*16 +: 16] = a;
        i_req_b[k*16 +: 16] = b;
        i_req_c[k]          = c;
    endtask

    // Single-requester handshake; returns positioned in the CALC cycle.
    task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b, input logic c);
        set_req(k, a, b, c);
        i_req_valid = 4'b0001 << k;
        tick();
        i_req_valid = '0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({o_rsp_valid, o_rsp_sum, o_rsp_carry, o_rsp_id, o_busy, o_req_ready} !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b sum=%h carry=%b id=%0d busy=%b ready=%b required all zero",
                     o_rsp_valid, o_rsp_sum, o_rsp_carry, o_rsp_id, o_busy, o_req_ready);
        end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_req(2, 16'h1234, 16'h0F0F, 1'b1);
        i_req_valid = 4'b0100;
        #1;
        vectors++;
        if (o_req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_ready: got %b required 0100", o_req_ready);
        end
        tick();
        i_req_valid = '0;
        vectors++;
        if (o_busy !== 1'b1 || o_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_calc: got busy=%b valid=%b required busy=1 valid=0", o_busy, o_rsp_valid);
        end
        tick();
        vectors++;
        if (o_rsp_valid !== 1'b1 || o_rsp_sum !== 16'h2144 || o_rsp_carry !== 1'b0 || o_rsp_id !== 2'd2) begin
            miscompares++;
            $display("FAIL single_rsp: got valid=%b sum=%h carry=%b id=%0d required 1 2144 0 2",
                     o_rsp_valid, o_rsp_sum, o_rsp_carry, o_rsp_id);
        end
        tick();
        vectors++;
        if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: got valid=%b busy=%b required 0 0", o_rsp_valid, o_busy);
        end
    endtask

    task automatic test_overflow();
        issue(3, 16'hFFFF, 16'h0001, 1'b0);
        tick();
        vectors++;
        if (o_rsp_sum !== 16'h0000 || o_rsp_carry !== 1'b1 || o_rsp_id !== 2'd3) begin
            miscompares++;
            $display("FAIL overflow_a: got sum=%h carry=%b id=%0d required 0000 1 3", o_rsp_sum, o_rsp_carry, o_rsp_id);
        end
        tick();
        issue(0, 16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        vectors++;
        if (o_rsp_sum !== 16'hFFFF || o_rsp_carry !== 1'b1 || o_rsp_id !== 2'd0) begin
            miscompares++;
            $display("FAIL overflow_b: got sum=%h carry=%b id=%0d required ffff 1 0", o_rsp_sum, o_rsp_carry, o_rsp_id);
        end
        tick();
    endtask

    task automatic test_wrap();
        issue(2, 16'h0001, 16'h0002, 1'b0);
        tick();
        tick();
        set_req(1, 16'h0010, 16'h0020, 1'b0);
        i_req_valid = 4'b0010;
        #1;
        vectors++;
        if (o_req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL wrap_grant: got %b required 0010", o_req_ready);
        end
        tick();
        i_req_valid = '0;
        tick();
        vectors++;
        if (o_rsp_id !== 2'd1 || o_rsp_sum !== 16'h0030) begin
            miscompares++;
            $display("FAIL wrap_rsp: got id=%0d sum=%h required 1 0030", o_rsp_id, o_rsp_sum);
        end
        tick();
        i_req_valid = 4'b0110;
        #1;
        vectors++;
        if (o_req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL wrap_pointer: got %b required 0100", o_req_ready);
        end
        tick();
        i_req_valid = '0;
        tick();
        vectors++;
        if (o_rsp_id !== 2'd2 || o_rsp_sum !== 16'h0003) begin
            miscompares++;
            $display("FAIL wrap_rsp2: got id=%0d sum=%h required 2 0003", o_rsp_id, o_rsp_sum);
        end
        tick();
    endtask

    task automatic test_backpressure();
        i_rsp_ready = 1'b0;
        issue(2, 16'h00FF, 16'h0F00, 1'b0);
        tick();
        i_req_valid = 4'b1111;
        for (int n = 0; n < 10; n++) begin
            vectors++;
            if (o_rsp_valid !== 1'b1 || o_rsp_sum !== 16'h0FFF || o_rsp_carry !== 1'b0 ||
                o_rsp_id !== 2'd2 || o_req_ready !== 4'b0000 || o_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got valid=%b sum=%h carry=%b id=%0d ready=%b busy=%b required 1 0fff 0 2 0000 1",
                         n, o_rsp_valid, o_rsp_sum, o_rsp_carry, o_rsp_id, o_req_ready, o_busy);
            end
            tick();
        end
        i_rsp_ready = 1'b1;
        #1;
        vectors++;
        if (o_req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL bp_no_grant: got %b required 0000", o_req_ready);
        end
        i_req_valid = '0;
        tick();
        vectors++;
        if (o_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got valid=%b required 0", o_rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        issue(2, 16'h5555, 16'h5555, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_rsp_valid, o_rsp_sum, o_rsp_carry, o_rsp_id, o_busy, o_req_ready} !== 25'd0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got valid=%b sum=%h carry=%b id=%0d busy=%b ready=%b required all zero",
                     o_rsp_valid, o_rsp_sum, o_rsp_carry, o_rsp_id, o_busy, o_req_ready);
        end
        tick();
        tick();
        i_rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            vectors++;
            if (o_rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_stale[%0d]: got valid=%b required 0", n, o_rsp_valid);
            end
        end
        set_req(3, 16'h0001, 16'h0001, 1'b0);
        i_req_valid = 4'b1100;
        #1;
        vectors++;
        if (o_req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL rstmid_grant: got %b required 0100", o_req_ready);
        end
        tick();
        i_req_valid = '0;
        tick();
        vectors++;
        if (o_rsp_id !== 2'd2 || o_rsp_sum !== 16'hAAAA) begin
            miscompares++;
            $display("FAIL rstmid_rsp: got id=%0d sum=%h required 2 aaaa", o_rsp_id, o_rsp_sum);
        end
        tick();
    endtask

    task automatic test_fairness();
        logic [16:0] exp_res;
        logic [15:0] a;
        int          exp_id;
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            a = 16'(16'h1000 * (k + 1) + k);
            set_req(k, a, 16'h0F0F, k[0]);
        end
        i_rsp_ready = 1'b1;
        i_req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 8; n++) begin
            exp_id = n % 4;
            a       = 16'(16'h1000 * (exp_id + 1) + exp_id);
            exp_res = {1'b0, a} + 17'h0F0F + 17'(exp_id % 2);
            vectors++;
            if (o_req_ready !== (4'b0001 << exp_id)) begin
                miscompares++;
                $display("FAIL fair_grant[%0d]: got %b required id %0d", n, o_req_ready, exp_id);
            end
            tick();
            vectors++;
            if (o_rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL fair_calc[%0d]: got valid=%b required 0", n, o_rsp_valid);
            end
            tick();
            vectors++;
            if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'(exp_id) || {o_rsp_carry, o_rsp_sum} !== exp_res) begin
                miscompares++;
                $display("FAIL fair_rsp[%0d]: got valid=%b id=%0d res=%h required 1 %0d %h",
                         n, o_rsp_valid, o_rsp_id, {o_rsp_carry, o_rsp_sum}, exp_id, exp_res);
            end
            tick();
        end
        i_req_valid = '0;
    endtask

    initial begin
        i_req_valid = '0;
        i_req_a     = '0;
        i_req_b     = '0;
        i_req_c     = '0;
        i_rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_overflow();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_fairness();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
